// File: rtl/vx_writeback_arb_pkg.sv
// Shared writeback types and widths for the writeback arbiter slice.
// Field widths mirror the GPU-wide configuration; THREAD_CNT must equal NUM_THREADS.
package vx_writeback_arb_pkg;
  localparam int NUM_THREADS   = 4;
  localparam int UUID_WIDTH    = 8;
  localparam int NW_BITS       = 2;
  localparam int NR_BITS       = 5;
  localparam int XLEN          = 32;
  localparam int PERF_CTR_BITS = 44;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]               uuid;
    logic [NW_BITS-1:0]                  wid;
    logic [NUM_THREADS-1:0]              tmask;
    logic [XLEN-1:0]                     pc;
    logic                                wb;
    logic [NR_BITS-1:0]                  rd;
    logic [NUM_THREADS-1:0][XLEN-1:0]    data;
    logic                                eop;
  } wb_data_t;

  // Round-robin successor with wrap from n-1 back to 0.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/vx_writeback_arb_if.sv
// Result-source and writeback bundle between execute units and the writeback arbiter.
interface vx_writeback_arb_if
  import vx_writeback_arb_pkg::*;
#(
  parameter int NUM_SRCS = 3
);
  logic [NUM_SRCS-1:0]   src_valid;
  logic [NUM_SRCS-1:0]   src_ready;
  wb_data_t [NUM_SRCS-1:0] src_data;
  logic                  wb_valid;
  wb_data_t              wb_data;
  logic                  commit_valid;
  logic                  commit_ready;

  modport slave  (input  src_valid, src_data,
                  output src_ready, wb_valid, wb_data, commit_valid, commit_ready);
  modport master (output src_valid, src_data,
                  input  src_ready, wb_valid, wb_data, commit_valid, commit_ready);
endinterface

// File: rtl/vx_writeback_arb_rr_arbiter.sv
// Round-robin selector with grant lock; ptr always holds the last granted source,
// so while locked the locked source is simply ptr.
module vx_wb_rr_arbiter
  import vx_writeback_arb_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         lock,
  output logic [N-1:0] grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] sel;
  logic [PW-1:0] gidx;
  logic          found;
  int            scan;

  always_comb begin
    grant = '0;
    found = 1'b0;
    scan  = int'(ptr);
    sel   = ptr;
    if (lock) begin
      grant[ptr] = req[ptr];
    end else begin
      for (int k = 0; k < N; k++) begin
        scan = rr_next(scan, N);
        sel  = PW'(scan);
        if (req[sel] && !found) begin
          grant[sel] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gidx = ptr;
    for (int i = 0; i < N; i++)
      if (grant[i]) gidx = PW'(i);
  end

  always_ff @(posedge clk) begin
    if (reset)       ptr <= PW'(N - 1);
    else if (|grant) ptr <= gidx;
  end
endmodule

// File: rtl/vx_writeback_arb.sv
// Writeback arbiter: one result packet per cycle from NUM_SRCS execute units, registered
// to the regfile writeback port. Optional stall counter under WB_ARB_PERF_EN.
module vx_writeback_arb
  import vx_writeback_arb_pkg::*;
#(
  parameter int NUM_SRCS   = 3,
  parameter int THREAD_CNT = NUM_THREADS,
  parameter int CORE_ID    = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  vx_writeback_arb_if.slave        bus
`ifdef WB_ARB_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0] perf_stalls
`endif
);
  if (THREAD_CNT != NUM_THREADS) begin : g_bad_thread_cnt
    $error("THREAD_CNT must match the packet lane count");
  end
  if (CORE_ID < 0) begin : g_bad_core_id
    $error("CORE_ID must be non-negative");
  end

  logic [NUM_SRCS-1:0] grant;
  logic                locked;
  logic                fire;
  wb_data_t            sel_data;
  logic                wb_valid_r;
  logic                commit_valid_r;
  wb_data_t            wb_data_r;

  vx_wb_rr_arbiter #(.N(NUM_SRCS)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (bus.src_valid),
    .lock  (locked),
    .grant (grant)
  );

  // grant is already masked by valid, so any grant bit is a handshake.
  assign bus.src_ready = grant;
  assign fire          = |grant;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_SRCS; i++)
      if (grant[i]) sel_data = bus.src_data[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      locked         <= 1'b0;
      wb_valid_r     <= 1'b0;
      commit_valid_r <= 1'b0;
      wb_data_r      <= '0;
    end else begin
      wb_valid_r     <= fire && sel_data.wb;
      commit_valid_r <= fire && sel_data.eop;
      if (fire)                locked    <= ~sel_data.eop;
      // Data only moves on real writebacks so idle cycles don't toggle the bus.
      if (fire && sel_data.wb) wb_data_r <= sel_data;
    end
  end

  assign bus.wb_valid     = wb_valid_r;
  assign bus.wb_data      = wb_data_r;
  assign bus.commit_valid = commit_valid_r;
  assign bus.commit_ready = 1'b1;

`ifdef WB_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset)                                perf_stalls <= '0;
    else if (|(bus.src_valid & ~bus.src_ready)) perf_stalls <= perf_stalls + 1'b1;
  end
`endif
endmodule

// File: doc/vx_writeback_arb.md
VX_WRITEBACK_ARB -- requirements
Module: VX_writeback_arb

Interface
REQ-001 SHALL have parameter NUM_SRCS, default 3, number of execute-unit result sources (ALU, LSU, SFU).
REQ-002 SHALL have parameter THREAD_CNT, default `NUM_THREADS, lanes per result.
REQ-003 SHALL have parameter CORE_ID, default 0, debug identification only.
REQ-004 SHALL have port clk, input, 1, the single clock for all state.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 SHALL have port src_valid, input, NUM_SRCS, a result packet is offered per source.
REQ-007 SHALL have port src_ready, output, NUM_SRCS, the packet is accepted this cycle.
REQ-008 SHALL have port src_data, input, NUM_SRCS x wb_data_t, fields uuid, wid, tmask, PC, wb, rd, data[THREAD_CNT][XLEN], eop.
REQ-009 SHALL have port wb_valid, output, 1, writeback packet toward the scoreboard/regfile; no backpressure.
REQ-010 SHALL have port wb_data, output, wb_data_t, the registered writeback packet.
REQ-011 SHALL have port commit_valid, output, 1, an instruction completed (eop packet accepted) this cycle.
REQ-012 SHALL have port commit_ready, output, 1, constant 1; pairs with commit_valid for the issue stage.

Function
REQ-013 SHALL accept at most one source packet per cycle.
REQ-014 SHALL select among valid sources round-robin, with priority starting at the index after the last granted source.
REQ-015 SHALL lock the grant on a source after accepting a packet with eop=0, until that source's eop=1 packet is accepted.
REQ-016 SHALL, while locked, deassert src_ready to all other sources regardless of their valid.
REQ-017 SHALL assert src_ready[i] combinationally only when source i is granted; no combinational path from wb outputs.
REQ-018 SHALL register the accepted packet: wb_valid rises exactly 1 cycle after src_valid&src_ready, only when the accepted packet has wb=1.
REQ-019 SHALL drive wb_valid=0 when the accepted packet has wb=0; the packet still counts toward commit.
REQ-020 SHALL pulse commit_valid 1 cycle after accepting any packet with eop=1, independent of wb.
REQ-021 SHALL hold wb_data stable while wb_valid=0 (no toggling of data on idle cycles).
REQ-022 SHALL sustain one packet per cycle with back-to-back grants to the same or different sources.
REQ-023 SHALL wrap the round-robin pointer from NUM_SRCS-1 to 0.
REQ-024 SHALL, when no source is valid, keep the pointer and lock state unchanged.

Reset
REQ-025 SHALL clear wb_valid, commit_valid, lock state, and set the round-robin pointer to NUM_SRCS-1 (source 0 highest priority first).
REQ-026 SHALL discard a locked multi-packet transfer interrupted by reset; after reset no source is locked.
REQ-027 SHALL reset wb_data to all-zeros.

Configuration
REQ-028 SHALL, with WB_ARB_PERF_EN defined, provide output perf_stalls[`PERF_CTR_BITS-1:0] counting cycles where any src_valid&~src_ready occurs, cleared on reset, wrapping on overflow.
REQ-029 SHALL, without WB_ARB_PERF_EN, omit the perf_stalls port and counter logic entirely.

Structure
REQ-030 SHALL take wb_data_t, field widths (UUID_WIDTH, NW_BITS, NR_BITS, XLEN), and PERF_CTR_BITS from the shared VX_gpu_pkg.
REQ-031 SHALL implement selection in one sub-module VX_wb_rr_arbiter (request vector, lock input, one-hot grant, pointer update).

Verification
REQ-032 Reset then src_valid=3'b111, all wb=1 eop=1 -> grants in order 0,1,2 on consecutive cycles; wb_valid high cycles 1-3; three commit_valid pulses.
REQ-033 LSU (src 1) sends 3 packets eop=0,0,1 while ALU (src 0) valid throughout -> src_ready[0]=0 for those 3 cycles; ALU granted on cycle 4.
REQ-034 SFU packet wb=0 eop=1 rd=5 -> wb_valid stays 0, commit_valid pulses once 1 cycle later.
REQ-035 Only src 2 valid for 4 cycles with data 0xA,0xB,0xC,0xD -> wb_data.data follows each 1 cycle later; no idle bubbles.
REQ-036 Reset asserted mid-lock (after LSU eop=0 packet) -> next cycle after reset release, ALU valid is granted immediately; wb_valid=0 during reset.
REQ-037 With WB_ARB_PERF_EN, 2 sources valid for 10 cycles (each eop=1) -> perf_stalls=10 (one loser per cycle); both sources granted 5 times.
